// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle RV32M multiply / divide / remainder unit.
// An iterative radix-2 shift-add multiplier and a restoring divider share
// one accumulator and one step counter. Operands are reduced to magnitudes
// at issue and the sign is re-applied in FIX. FAST_MUL=1 swaps the
// iterative multiply for a single-cycle full-width product.
module alu_muldiv #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
  localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic             busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    acc_q;      // mul: {0, hi, lo}; div: {partial rem (W+1), quotient}
  logic [WIDTH-1:0] mcand_q;    // multiplicand magnitude or divisor magnitude
  logic             negq_q;     // product / quotient needs negation
  logic             negr_q;     // remainder needs negation
  logic             dz_q;       // divide-by-zero seen at issue

  // Issue-time decode of the incoming operation
  logic             sgn_a, sgn_b, a_neg, b_neg, is_div, b_zero, ovf, fast;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] fast_prod;

  // Per-cycle datapath step and final result selection
  logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
  logic [AW-1:0]      acc_d;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, remv, result_d;

  // Decode operand signedness, magnitudes and the short-cut cases at issue
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (op_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'b010: begin
        sgn_a = 1'b1;
        sgn_b = 1'b0;
      end
      default: begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
      end
    endcase
    a_neg = sgn_a & a_i[WIDTH-1];
    b_neg = sgn_b & b_i[WIDTH-1];
    if (a_neg) begin
      a_mag = ZERO_W - a_i;
    end else begin
      a_mag = a_i;
    end
    if (b_neg) begin
      b_mag = ZERO_W - b_i;
    end else begin
      b_mag = b_i;
    end
    is_div    = op_i[2];
    b_zero    = (b_i == ZERO_W);
    ovf       = is_div & ~op_i[0] & (a_i == MOST_NEG) & (b_i == ONES_W);
    fast      = (FAST_MUL == 1'b1) & ~op_i[2];
    fast_prod = {ZERO_W, a_mag} * {ZERO_W, b_mag};
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step
  always_comb begin
    mul_sum   = acc_q[AW-1:WIDTH] + {1'b0, mcand_q};
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, mcand_q};
    if (op_q[2]) begin
      if (!rem_diff[WIDTH]) begin
        acc_d = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {rem_shift, acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[AW-1:WIDTH], acc_q[WIDTH-1:1]};
      end
    end
  end

  // Sign correction on full-width values, then half / quotient / remainder select
  always_comb begin
    if (negq_q) begin
      prod = ZERO_2W - acc_q[2*WIDTH-1:0];
      quo  = ZERO_W - acc_q[WIDTH-1:0];
    end else begin
      prod = acc_q[2*WIDTH-1:0];
      quo  = acc_q[WIDTH-1:0];
    end
    if (negr_q) begin
      remv = ZERO_W - acc_q[2*WIDTH-1:WIDTH];
    end else begin
      remv = acc_q[2*WIDTH-1:WIDTH];
    end
    case (op_q)
      3'b000:                 result_d = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result_d = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         result_d = quo;
      3'b110, 3'b111:         result_d = remv;
      default:                result_d = ZERO_W;
    endcase
  end

  // Control FSM with registered outputs and operand/accumulator state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= ZERO_W;
      div_zero_q <= 1'b0;
      cnt_q      <= CNT_ZERO;
      op_q       <= 3'b000;
      acc_q      <= {AW{1'b0}};
      mcand_q    <= ZERO_W;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i && !kill_i) begin
            op_q    <= op_i;
            mcand_q <= b_mag;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            if (is_div && b_zero) begin
              // quotient all ones, remainder = raw dividend
              acc_q   <= {1'b0, a_i, ONES_W};
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              dz_q    <= 1'b1;
              state_q <= S_FIX;
            end else if (ovf) begin
              // quotient = most negative value, remainder 0
              acc_q   <= {1'b0, ZERO_W, a_i};
              negq_q  <= 1'b0;
              negr_q  <= 1'b0;
              dz_q    <= 1'b0;
              state_q <= S_FIX;
            end else if (fast) begin
              acc_q   <= {1'b0, fast_prod};
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              dz_q    <= 1'b0;
              state_q <= S_FIX;
            end else begin
              acc_q   <= {1'b0, ZERO_W, a_mag};
              negq_q  <= a_neg ^ b_neg;
              negr_q  <= a_neg;
              dz_q    <= 1'b0;
              state_q <= S_CALC;
            end
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CALC: begin
          if (kill_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q <= S_FIX;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_FIX: begin
          if (kill_i) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            result_q   <= result_d;
            div_zero_q <= dz_q;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multi-cycle arithmetic unit. It extends the datapath's single-cycle combinational ALU with the RV32M multiply/divide/remainder operations.
- Sits beside the main ALU in the execute stage. The control unit issues `start`, stalls the pipeline while `busy`, and captures `result` when `done` pulses.
- Uses an iterative radix-2 shift-add multiplier and a restoring divider, sharing one accumulator and one counter.
- Parameter `FAST_MUL` optionally switches multiplies to a single-cycle path.

Parameters:
- WIDTH, 32, operand and result width in bits; legal values are 8 to 64, even.
- FAST_MUL, 0, 1 means multiplies complete via a combinational full-width product; 0 means iterative multiply.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the unit is idle.
- kill  input  1  synchronous abort of an in-flight operation (pipeline flush).
- op  input  3  RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- a  input  WIDTH  rs1 operand, signed or unsigned per op.
- b  input  WIDTH  rs2 operand, signed or unsigned per op.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; `result` is valid in that cycle.
- result  output  WIDTH  registered result; holds its value until the next `done`.
- div_zero  output  1  registered with `result`; set when a div/rem op had b == 0.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, result=0, div_zero=0, counter=0. Reset overrides every other input in any state, including mid-operation.
- States:
  - IDLE: if start=1 (and kill=0), latch op, the operand magnitudes, and the sign flags.
    - mul/mulh: both operands signed.
    - mulhsu: a signed, b unsigned.
    - div/rem: both operands signed; the result sign is sign(a)^sign(b) for the quotient and sign(a) for the remainder.
    - Load counter=WIDTH, then go to CALC. Special case: if the op is div/rem with b==0, or signed overflow (a = most negative value and b = -1), or FAST_MUL=1 with a mul op, go directly to FIX.
  - CALC: perform one shift-add or shift-subtract step per cycle and decrement the counter. When the counter transitions 1 to 0, go to FIX.
  - FIX: apply two's-complement sign correction and select the low or high half (mul selects low; mulh/mulhsu/mulhu select high). Load `result` and `div_zero`, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency, with start sampled at edge 0: iterative ops raise `done` in the cycle after edge WIDTH+1, i.e. WIDTH+2 cycles after the start cycle (34 for WIDTH=32). Special or fast cases raise `done` 2 cycles after start.
- Throughput: a new start is accepted in the cycle after DONE, because the unit is idle again. Back-to-back ops are therefore spaced WIDTH+3 cycles apart.
- start while busy=1: ignored. Latched operands and op are unaffected, and nothing is queued.
- kill=1 in CALC or FIX: go to IDLE at the next edge, with no done pulse; `result` and `div_zero` keep their previous values.
- kill=1 in DONE: no effect, the pulse completes.
- kill=1 together with start in IDLE: start is ignored.
- Division by zero: quotient = all ones, remainder = a, div_zero=1.
- Signed overflow: quotient = a (the most negative value), remainder = 0, div_zero=0.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- Internal widths:
  - Multiplier accumulator is 2*WIDTH bits.
  - Divider partial remainder is WIDTH+1 bits.
  - Sign correction is applied on the full 2*WIDTH product before high-half selection.
- Operands a and b may change after the start cycle without affecting the operation.

Test Plan:
- Reset behaviour: assert rst mid-CALC of a div → next cycle busy=0, done=0, result=0. A subsequent mul of 7 and 0xFFFFFFF9 → result 0xFFFFFFCF at cycle start+34.
- High-half multiplies:
  - mulh 0x80000000 × 0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - Repeat all three with FAST_MUL=1 → same values, done 2 cycles after start.
- Signed divide and remainder: div 0xFFFFFFF9 / 2 → 0xFFFFFFFD; rem → 0xFFFFFFFF. divu 0xFFFFFFF9 / 2 → 0x7FFFFFFC; remu → 1.
- Division corner cases:
  - div 5 / 0 → 0xFFFFFFFF with div_zero=1, 2-cycle latency.
  - rem 5 / 0 → 5.
  - div 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - rem 0x80000000 / 0xFFFFFFFF → 0 with div_zero=0.
- Start and kill handling:
  - Pulse start again at cycle start+5 with different operands → ignored; the first result is returned unchanged.
  - Assert kill at cycle start+10 → no done pulse, result holds its previous value, busy=0 next cycle.
- Width generalisation: with WIDTH=16, div 0x8000 / 0xFFFF → 0x8000 and mul 0x00FF × 0x00FF → 0xFE01, done at start+18. Back-to-back ops are accepted exactly one cycle after done.
